exu_csr_pipe: RTL

Parametrised CSR execution unit for the EXU stage. It accepts CSR instructions over a valid/ready handshake and decodes all six Zicsr forms, including the immediate forms. It computes the CSR write value and the GPR writeback value, then queues the results in a DEPTH-entry output FIFO. The FIFO drains to the writeback/CSR-file stage over a second valid/ready handshake. It also adds write suppression, read-only CSR detection and flush on interrupt.

---
 rtl/csr_pipe_pkg.sv | 44 ++++
 rtl/csr_pipe_fifo.sv | 87 ++++++++
 rtl/exu_csr_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/csr_pipe_pkg.sv
// -----------------------------------------------------------------------------
// csr_pipe_pkg
//
// Shared definitions for the CSR execution pipe:
//   csr_op_e       funct3 encodings of the six Zicsr instructions
//   CSR_RO_PREFIX  top two CSR address bits that mark a read-only CSR
//   csr_entry_t    one queued result: CSR write side plus GPR writeback side
//
// The entry layout is fixed here, so the width parameters of exu_csr_pipe
// default to (and are expected to equal) the ENT_* widths below.
// -----------------------------------------------------------------------------
package csr_pipe_pkg;

    localparam int ENT_DATA_W     = 32;
    localparam int ENT_CSR_ADDR_W = 12;
    localparam int ENT_REG_ADDR_W = 5;

    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    typedef struct packed {
        logic                      csr_we;
        logic [ENT_CSR_ADDR_W-1:0] csr_waddr;
        logic [ENT_DATA_W-1:0]     csr_wdata;
        logic                      reg_we;
        logic [ENT_REG_ADDR_W-1:0] reg_waddr;
        logic [ENT_DATA_W-1:0]     reg_wdata;
        logic                      illegal;
    } csr_entry_t;

    // Set/clear forms only write when they actually have bits to apply.
    function automatic logic op_is_conditional(input logic [2:0] op);
        return (op[1:0] == 2'b10) || (op[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_pipe_fifo.sv
// -----------------------------------------------------------------------------
// csr_pipe_fifo
//
// Generic DEPTH-entry synchronous FIFO with a synchronous flush.
// Control state (pointers, occupancy) resets asynchronously; the storage
// array is not reset because nothing downstream may look at it while empty.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and data (ignored when full and not popping)
//   pop        read request (ignored when empty)
//   flush      next edge empties the FIFO; push and pop are ignored
//   dout       head entry (only meaningful while empty is low)
//   count      occupancy, 0..DEPTH
//   empty/full occupancy flags
// -----------------------------------------------------------------------------
module csr_pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push at full is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/exu_csr_pipe.sv
// -----------------------------------------------------------------------------
// exu_csr_pipe
//
// CSR execution unit of the EXU stage. Accepts Zicsr instructions over a
// valid/ready handshake, computes the new CSR value and the GPR writeback
// value (the old CSR value), flags illegal encodings and writes to read-only
// CSRs, and queues the result in a DEPTH-entry FIFO that drains to the
// writeback/CSR-file stage over a second valid/ready handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid_i/ready request handshake
//   op_i              funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//   src_i, zimm_i     rs1 value / 5-bit immediate
//   src_is_x0_i       rs1 index (or zimm) is zero
//   csr_addr_i        target CSR
//   csr_rdata_i       current CSR value, aligned with the request
//   reg_waddr_i       rd
//   flush_i           drops every queued entry and blocks the request
//   out_valid_o/ready result handshake
//   csr_we/waddr/wdata_o, reg_we/waddr/wdata_o, illegal_o  head entry fields,
//                     forced to zero while the FIFO is empty
//   csr_stall_o       request is waiting on ready
//   count_o           FIFO occupancy
// -----------------------------------------------------------------------------
module exu_csr_pipe
    import csr_pipe_pkg::*;
#(
    parameter int DATA_W     = ENT_DATA_W,
    parameter int CSR_ADDR_W = ENT_CSR_ADDR_W,
    parameter int REG_ADDR_W = ENT_REG_ADDR_W,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [2:0]                   op_i,
    input  logic [DATA_W-1:0]            src_i,
    input  logic [4:0]                   zimm_i,
    input  logic                         src_is_x0_i,
    input  logic [CSR_ADDR_W-1:0]        csr_addr_i,
    input  logic [DATA_W-1:0]            csr_rdata_i,
    input  logic [REG_ADDR_W-1:0]        reg_waddr_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         csr_we_o,
    output logic [CSR_ADDR_W-1:0]        csr_waddr_o,
    output logic [DATA_W-1:0]            csr_wdata_o,
    output logic                         reg_we_o,
    output logic [REG_ADDR_W-1:0]        reg_waddr_o,
    output logic [DATA_W-1:0]            reg_wdata_o,
    output logic                         illegal_o,
    output logic                         csr_stall_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] new_val;
    logic              write_intent;
    logic              bad_op;
    logic              ro_csr;
    logic              illegal;
    csr_entry_t        req_entry;
    csr_entry_t        head_entry;
    csr_entry_t        head_vis;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    // Decode and compute: operand select, new CSR value, write intent.
    always_comb begin
        opnd         = op_i[2] ? DATA_W'(zimm_i) : src_i;
        new_val      = opnd;
        write_intent = 1'b1;
        bad_op       = 1'b0;
        case (op_i)
            CSR_RW, CSR_RWI: begin
                new_val = opnd;
            end
            CSR_RS, CSR_RSI: begin
                new_val = csr_rdata_i | opnd;
            end
            CSR_RC, CSR_RCI: begin
                new_val = csr_rdata_i & ~opnd;
            end
            default: begin
                bad_op = 1'b1;
            end
        endcase
        // Set/clear with a zero source is a pure read and must not write.
        if (op_is_conditional(op_i) && src_is_x0_i) begin
            write_intent = 1'b0;
        end
    end

    // Only an actual write to a read-only CSR traps; reading one is fine.
    assign ro_csr  = (csr_addr_i[CSR_ADDR_W-1 -: 2] == CSR_RO_PREFIX);
    assign illegal = bad_op | (write_intent & ro_csr);

    always_comb begin
        req_entry           = '0;
        req_entry.csr_we    = ~illegal & write_intent;
        req_entry.csr_waddr = csr_addr_i;
        req_entry.csr_wdata = new_val;
        req_entry.reg_we    = ~illegal & (reg_waddr_i != '0);
        req_entry.reg_waddr = reg_waddr_i;
        req_entry.reg_wdata = csr_rdata_i;
        req_entry.illegal   = illegal;
    end

    // Handshakes: a full FIFO still accepts when the head drains this cycle.
    assign req_ready_o = ~flush_i & (~fifo_full | out_ready_i);
    assign push        = req_valid_i & req_ready_o & ~flush_i;
    assign out_valid_o = ~fifo_empty;
    assign pop         = out_valid_o & out_ready_i;
    assign csr_stall_o = req_valid_i & ~req_ready_o;

    // ---- FIFO stage boundary: results appear at the head the cycle after accept
    csr_pipe_fifo #(
        .WIDTH ($bits(csr_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req_entry),
        .pop   (pop),
        .flush (flush_i),
        .dout  (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Stale storage must never leak out, so head fields read zero while empty.
    assign head_vis = out_valid_o ? head_entry : '0;

    assign csr_we_o    = head_vis.csr_we;
    assign csr_waddr_o = head_vis.csr_waddr;
    assign csr_wdata_o = head_vis.csr_wdata;
    assign reg_we_o    = head_vis.reg_we;
    assign reg_waddr_o = head_vis.reg_waddr;
    assign reg_wdata_o = head_vis.reg_wdata;
    assign illegal_o   = head_vis.illegal;
    assign count_o     = fifo_count;

endmodule
